// File: rtl/gpio_ctrl.sv
// GPIO controller: direction, atomic set/clear/toggle, synchronised inputs,
// per-pin rising/falling edge interrupts with sticky write-1-to-clear status.
module gpio_ctrl #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sel,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [3:0] A_DATA_OUT = 4'd0;
  localparam logic [3:0] A_DIR      = 4'd1;
  localparam logic [3:0] A_DATA_IN  = 4'd2;
  localparam logic [3:0] A_SET      = 4'd3;
  localparam logic [3:0] A_CLR      = 4'd4;
  localparam logic [3:0] A_TGL      = 4'd5;
  localparam logic [3:0] A_RISE_EN  = 4'd6;
  localparam logic [3:0] A_FALL_EN  = 4'd7;
  localparam logic [3:0] A_STATUS   = 4'd8;
  localparam logic [3:0] A_INFO     = 4'd9;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_status;
  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] din_p1;
  logic [WIDTH-1:0] prev_p2;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] wd;
  logic             wr;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    return 32'(v);
  endfunction

  assign wr = sel & we;
  assign wd = wdata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^wdata[31:WIDTH];
    end
  endgenerate

  // Stage p0/p1: synchroniser chain, last stage is the architectural DATA_IN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign din_p1 = sync_p[SYNC_STAGES-1];

  // Stage p2: previous sample for edge detection
  always_ff @(posedge clk) begin
    if (!resetn) prev_p2 <= '0;
    else         prev_p2 <= din_p1;
  end

  assign edge_set = (din_p1 & ~prev_p2 & rise_en) | (~din_p1 & prev_p2 & fall_en);
  assign w1c_mask = (wr && addr == A_STATUS) ? wd : '0;

  // A new qualifying edge overrides a simultaneous clear
  always_ff @(posedge clk) begin
    if (!resetn) irq_status <= '0;
    else         irq_status <= (irq_status & ~w1c_mask) | edge_set;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_out <= RESET_OUT;
      dir      <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (wr) begin
      case (addr)
        A_DATA_OUT: data_out <= wd;
        A_DIR:      dir      <= wd;
        A_SET:      data_out <= data_out | wd;
        A_CLR:      data_out <= data_out & ~wd;
        A_TGL:      data_out <= data_out ^ wd;
        A_RISE_EN:  rise_en  <= wd;
        A_FALL_EN:  fall_en  <= wd;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        A_DATA_OUT: rdata = zext(data_out);
        A_DIR:      rdata = zext(dir);
        A_DATA_IN:  rdata = zext(din_p1);
        A_RISE_EN:  rdata = zext(rise_en);
        A_FALL_EN:  rdata = zext(fall_en);
        A_STATUS:   rdata = zext(irq_status);
        A_INFO:     rdata = {24'b0, 8'(WIDTH)};
        default:    rdata = '0;
      endcase
    end
  end

  assign gpio_out = data_out;
  assign gpio_oe  = dir;
  assign irq      = |irq_status;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: directed scenarios with fixed expectations,
// then randomized traffic checked against a pad-sample-history reference model.
module tb_gpio_ctrl;

  localparam int            W   = 8;
  localparam int            S   = 2;
  localparam logic [W-1:0]  RST = 8'hA5;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          sel = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [W-1:0]  gpio_in = '0;
  logic [W-1:0]  gpio_out;
  logic [W-1:0]  gpio_oe;
  logic          irq;

  int checks = 0;
  int failures = 0;
  logic fin_chk = 1'b0;

  typedef struct {
    string        name;
    logic [31:0]  r;
    logic [W-1:0] o;
    logic [W-1:0] oe;
    logic         q;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(S), .RESET_OUT(RST)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: registers as plain values, inputs as a history of pad
  // samples taken at each posedge (hist[0] newest). DATA_IN is the sample from
  // S-1 edges ago; an edge is a difference between two consecutive DATA_IN values.
  logic [W-1:0] m_out, m_dir, m_re, m_fe, m_st;
  logic [W-1:0] hist [0:S];
  logic [W-1:0] m_din, m_prev, m_wd;
  assign m_din  = hist[S-1];
  assign m_prev = hist[S];
  assign m_wd   = wdata[W-1:0];

  always @(posedge clk) begin
    if (!resetn) begin
      m_out <= RST; m_dir <= '0; m_re <= '0; m_fe <= '0; m_st <= '0;
      for (int j = 0; j <= S; j++) hist[j] <= '0;
    end else begin
      hist[0] <= gpio_in;
      for (int j = 1; j <= S; j++) hist[j] <= hist[j-1];
      m_st <= (m_st & ~((sel && we && addr == 4'd8) ? m_wd : '0))
            | (m_din & ~m_prev & m_re) | (~m_din & m_prev & m_fe);
      if (sel && we) begin
        case (addr)
          4'd0: m_out <= m_wd;
          4'd1: m_dir <= m_wd;
          4'd3: m_out <= m_out | m_wd;
          4'd4: m_out <= m_out & ~m_wd;
          4'd5: m_out <= m_out ^ m_wd;
          4'd6: m_re  <= m_wd;
          4'd7: m_fe  <= m_wd;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] model_rd(input logic [3:0] a);
    case (a)
      4'd0: return 32'(m_out);
      4'd1: return 32'(m_dir);
      4'd2: return 32'(m_din);
      4'd6: return 32'(m_re);
      4'd7: return 32'(m_fe);
      4'd8: return 32'(m_st);
      4'd9: return 32'(W);
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: every cycle presenting a read is matched against the queue head
  always @(negedge clk) begin
    if (resetn && sel && !we) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: addr=%0d rdata=%h, required a queued expectation", addr, rdata);
      end else begin
        mon_e = sbq.pop_front();
        if (rdata !== mon_e.r || gpio_out !== mon_e.o || gpio_oe !== mon_e.oe || irq !== mon_e.q) begin
          failures++;
          $display("FAIL %s: got rdata=%h out=%h oe=%h irq=%b, required rdata=%h out=%h oe=%h irq=%b",
                   mon_e.name, rdata, gpio_out, gpio_oe, irq, mon_e.r, mon_e.o, mon_e.oe, mon_e.q);
        end
      end
    end
    if (fin_chk) begin
      checks++;
      if (sbq.size() != 0) begin
        failures++;
        $display("FAIL drain: got %0d unconsumed expectations, required 0", sbq.size());
      end
    end
  end

  task automatic cyc(input logic s, input logic w, input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    sel = s; we = w; addr = a; wdata = d;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 4'd0, 32'h0);
  endtask

  task automatic pad(input logic [W-1:0] v);
    cyc(1'b0, 1'b0, 4'd0, 32'h0);
    gpio_in = v;
  endtask

  task automatic push(input string n, input logic [31:0] r, input logic [W-1:0] o,
                      input logic [W-1:0] oe, input logic q);
    exp_t e;
    e.name = n; e.r = r; e.o = o; e.oe = oe; e.q = q;
    sbq.push_back(e);
  endtask

  task automatic rd_full(input logic [3:0] a, input logic [31:0] r, input logic [W-1:0] o,
                         input logic [W-1:0] oe, input logic q, input string n);
    cyc(1'b1, 1'b0, a, 32'h0);
    push(n, r, o, oe, q);
  endtask

  task automatic rdc(input logic [3:0] a, input logic [31:0] r, input string n);
    cyc(1'b1, 1'b0, a, 32'h0);
    push(n, r, m_out, m_dir, |m_st);
  endtask

  task automatic rdci(input logic [3:0] a, input logic [31:0] r, input logic q, input string n);
    cyc(1'b1, 1'b0, a, 32'h0);
    push(n, r, m_out, m_dir, q);
  endtask

  task automatic rd(input logic [3:0] a, input string n);
    cyc(1'b1, 1'b0, a, 32'h0);
    push(n, model_rd(a), m_out, m_dir, |m_st);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; resetn = 1'b0;
    repeat (n) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    int r;
    do_reset(2);

    rd_full(4'd0, 32'hA5, 8'hA5, 8'h00, 1'b0, "rst_data_out");
    rd_full(4'd1, 32'h00, 8'hA5, 8'h00, 1'b0, "rst_dir");
    rd_full(4'd6, 32'h00, 8'hA5, 8'h00, 1'b0, "rst_rise_en");
    rd_full(4'd7, 32'h00, 8'hA5, 8'h00, 1'b0, "rst_fall_en");
    rd_full(4'd8, 32'h00, 8'hA5, 8'h00, 1'b0, "rst_status");
    rd_full(4'd9, 32'h08, 8'hA5, 8'h00, 1'b0, "info");
    rdc(4'd12, 32'h0, "unmapped");

    wr(4'd0, 32'h0F); wr(4'd3, 32'h30); rdc(4'd0, 32'h3F, "set");
    wr(4'd4, 32'h05); rdc(4'd0, 32'h3A, "clr");
    wr(4'd5, 32'hFF); rdc(4'd0, 32'hC5, "tgl");
    rdc(4'd3, 32'h0, "rd_set_zero");
    rdc(4'd4, 32'h0, "rd_clr_zero");
    rdc(4'd5, 32'h0, "rd_tgl_zero");
    wr(4'd0, 32'hFFFF_FF00); rdc(4'd0, 32'h0, "upper_bits_ignored");
    wr(4'd1, 32'h0000_00F0); rdc(4'd1, 32'hF0, "dir_rw");

    wr(4'd6, 32'h04);
    pad(8'h04);
    rdci(4'd2, 32'h00, 1'b0, "din_at_k");
    rdci(4'd2, 32'h04, 1'b0, "din_after_k1");
    rdci(4'd8, 32'h04, 1'b1, "rise_irq_k2");
    wr(4'd8, 32'h04); rdci(4'd8, 32'h00, 1'b0, "w1c_clear");
    pad(8'h00); idle(3);
    rdci(4'd8, 32'h00, 1'b0, "fall_disabled");

    wr(4'd7, 32'h01);
    pad(8'h01); idle(3);
    rdci(4'd8, 32'h00, 1'b0, "rise0_disabled");
    pad(8'h00); idle(1);
    wr(4'd8, 32'h01);
    rdci(4'd8, 32'h01, 1'b1, "set_wins");
    wr(4'd8, 32'h01); rdci(4'd8, 32'h00, 1'b0, "clear_after_collision");

    wr(4'd6, 32'h00);
    pad(8'h80); idle(3);
    wr(4'd6, 32'h80); idle(2);
    rdci(4'd8, 32'h00, 1'b0, "no_retroactive");
    pad(8'h00); idle(3);
    pad(8'h80); idle(2);
    rdci(4'd8, 32'h80, 1'b1, "rise7");
    wr(4'd6, 32'h00); rdci(4'd8, 32'h80, 1'b1, "disable_keeps_status");
    wr(4'd1, 32'h3C); rdci(4'd1, 32'h3C, 1'b1, "dir_set");
    do_reset(1);
    rd_full(4'd8, 32'h00, 8'hA5, 8'h00, 1'b0, "midrst_status");
    rd_full(4'd1, 32'h00, 8'hA5, 8'h00, 1'b0, "midrst_dir");
    idle(3);
    rdci(4'd2, 32'h80, 1'b0, "din_after_reset");
    rdci(4'd8, 32'h00, 1'b0, "held_high_no_status");

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 60)       wr(4'($urandom_range(0, 15)), $urandom);
      else if (r < 130) rd(4'($urandom_range(0, 15)), "rand_rd");
      else if (r < 175) pad(W'($urandom));
      else if (r < 198) idle(1);
      else              do_reset($urandom_range(1, 2));
    end

    idle(2);
    @(posedge clk); #1 fin_chk = 1'b1;
    @(negedge clk); #1 fin_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
